data_cache: RTL
===============

Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline memory stage and the byte-addressed data memory.
- Keeps the data memory's load/store semantics: byte accesses zero-extended, word accesses little-endian.
- Raises a stall to the pipeline on a load miss and refills one word from data memory.

Parameters:
- WIDTH, 32, address and data width.
- IDX_BITS, 3, index width; number of lines SETS = 2**IDX_BITS, one 32-bit word per line.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cpu_re  in  1  load request
- cpu_we  in  1  store request
- cpu_mem_type  in  1  1 = byte, 0 = word
- cpu_addr  in  WIDTH  byte address
- cpu_wd  in  WIDTH  store data (byte stores use [7:0])
- cpu_rd  out  WIDTH  load data
- stall  out  1  pipeline must hold all cpu_* inputs stable while high
- mem_we  out  1  data memory write enable
- mem_mem_type  out  1  data memory byte/word select
- mem_addr  out  WIDTH  data memory address
- mem_wd  out  WIDTH  data memory write data
- mem_rd  in  WIDTH  data memory combinational read data

Behaviour:
- Address split:
  - off = A[1:0]
  - idx = A[IDX_BITS+1:2]
  - tag = A[WIDTH-1:IDX_BITS+2]
- Per line state: valid bit, tag, 32-bit data.
- Reset (synchronous): all valid bits cleared, FSM to IDLE. Outputs during and after reset: stall=0, mem_we=0, cpu_rd=0 when no load is active.
- Cacheable access: byte access, or word access with off==0.
- Uncached access: word access with off!=0. It passes straight through combinationally: mem_addr=cpu_addr, cpu_rd=mem_rd, stall=0, no line is changed.
- Store priority: cpu_we and cpu_re both high is treated as a store; cpu_re is ignored.
- FSM states IDLE, FETCH.
- IDLE, store:
  - mem_we=1, mem_addr=cpu_addr, mem_wd=cpu_wd, mem_mem_type=cpu_mem_type in the same cycle; stall=0.
  - On a hit, the line is updated at the edge: byte lane off for a byte store, whole word for a word store.
  - On a miss, no allocation.
- IDLE, load hit: cpu_rd is combinational, stall=0.
  - Word: line data.
  - Byte: {24'b0, lane off}.
- IDLE, load miss: stall=1, next state FETCH.
- FETCH:
  - stall=1, mem_we=0, mem_mem_type=0, mem_addr={cpu_addr[WIDTH-1:2],2'b00}.
  - At the edge: line[idx] gets data=mem_rd, tag, valid=1; next state IDLE.
  - The following IDLE cycle hits and drops stall.
- Miss penalty: exactly 2 stall cycles.
- When neither request is active: mem_we=0, cpu_rd=0, no state change.
- Reset asserted during FETCH: no fill, FSM to IDLE, stall=0 the next cycle, all lines invalid.
- Idle mem_* outputs: mem_addr=cpu_addr and mem_wd=cpu_wd, so the data memory always sees a defined address.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count [31:0] and miss_count [31:0], both cleared by rst.
  - hit_count increments on each cacheable load that completes without entering FETCH.
  - miss_count increments on each IDLE to FETCH transition.
  - Both wrap modulo 2**32; stores and uncached accesses do not count.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Memory 0x10000=0x44332211. After rst, word load 0x10000 -> stall high 2 cycles, FETCH mem_addr=0x10000, then cpu_rd=0x44332211; repeat load -> stall=0, cpu_rd=0x44332211.
- After fill, byte load 0x10002 -> cpu_rd=0x00000033, stall=0.
- Byte store 0xAB to 0x10001 (hit) -> same cycle mem_we=1, mem_mem_type=1, mem_addr=0x10001; next word load 0x10000 -> 0x4433AB11, no stall.
- IDX_BITS=3, memory 0x10020=0xDEADBEEF. Load 0x10000 (fill), load 0x10020 -> miss, 0xDEADBEEF; load 0x10000 -> misses again, 0x44332211.
- Word store 0x12345678 to 0x10040 (miss) -> mem_we=1, stall=0. Load 0x10040 -> miss, 2 stall cycles, 0x12345678.
- Word load 0x10001 -> cpu_rd=mem_rd same cycle, stall=0, no line filled.
- rst pulsed in FETCH -> stall=0 next cycle; reload 0x10000 misses again.
- With DCACHE_STATS_EN: after scenario 1, hit_count=1, miss_count=1.

Source files
------------

// File: rtl/data_cache_if.sv
// Bus bundle between the pipeline memory stage, the data cache and the byte-addressed data memory.
// The slave modport is the cache side; master is the pipeline-plus-memory side that surrounds it.
interface data_cache_if #(
  parameter int WIDTH = 32
);
  // Stall semantics: while stall is high the pipeline holds cpu_re, cpu_we,
  // cpu_mem_type, cpu_addr and cpu_wd stable; an access completes on the first
  // rising edge at which stall is low. The memory answers mem_rd combinationally.
  logic             cpu_re;
  logic             cpu_we;
  logic             cpu_mem_type;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             stall;
  logic             mem_we;
  logic             mem_mem_type;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  modport master (
    output cpu_re, cpu_we, cpu_mem_type, cpu_addr, cpu_wd, mem_rd,
    input  cpu_rd, stall, mem_we, mem_mem_type, mem_addr, mem_wd
  );

  modport slave (
    input  cpu_re, cpu_we, cpu_mem_type, cpu_addr, cpu_wd, mem_rd,
    output cpu_rd, stall, mem_we, mem_mem_type, mem_addr, mem_wd
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus,
  output logic         dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int SETS  = 2 ** IDX_BITS;
  localparam int TAG_W = WIDTH - IDX_BITS - 2;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [WIDTH-1:0]    data_q [SETS];

  logic [1:0]          off;
  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic                is_store;
  logic                is_load;
  logic                cacheable;
  logic                hit;
  logic [WIDTH-1:0]    line;
  logic [7:0]          lane;
  logic                fill_en;
  logic                wr_hit_en;

  assign off       = bus.cpu_addr[1:0];
  assign idx       = bus.cpu_addr[IDX_BITS+1:2];
  assign tag       = bus.cpu_addr[WIDTH-1:IDX_BITS+2];
  assign is_store  = bus.cpu_we;
  assign is_load   = bus.cpu_re & ~bus.cpu_we;
  assign cacheable = bus.cpu_mem_type | (off == 2'b00);
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign line      = data_q[idx];
  assign lane      = line[{off, 3'b000} +: 8];
  assign dbg_state = state;

  always_comb begin
    state_nxt        = state;
    bus.stall        = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_mem_type = bus.cpu_mem_type;
    bus.mem_addr     = bus.cpu_addr;
    bus.mem_wd       = bus.cpu_wd;
    bus.cpu_rd       = '0;
    fill_en          = 1'b0;
    wr_hit_en        = 1'b0;

    if (state == FETCH) begin
      bus.stall        = 1'b1;
      bus.mem_mem_type = 1'b0;
      bus.mem_addr     = {bus.cpu_addr[WIDTH-1:2], 2'b00};
      fill_en          = 1'b1;
      state_nxt        = IDLE;
    end else if (is_store) begin
      bus.mem_we = 1'b1;
      wr_hit_en  = cacheable && hit;
    end else if (is_load) begin
      if (!cacheable) begin
        bus.cpu_rd = bus.mem_rd;
      end else if (hit) begin
        bus.cpu_rd = bus.cpu_mem_type ? {{(WIDTH-8){1'b0}}, lane} : line;
      end else begin
        bus.stall = 1'b1;
        state_nxt = FETCH;
      end
    end

    // Reset wins over everything: quiet outputs and no array updates.
    if (rst) begin
      bus.stall  = 1'b0;
      bus.mem_we = 1'b0;
      bus.cpu_rd = '0;
      fill_en    = 1'b0;
      wr_hit_en  = 1'b0;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rd;
    end else if (wr_hit_en) begin
      if (bus.cpu_mem_type) data_q[idx][{off, 3'b000} +: 8] <= bus.cpu_wd[7:0];
      else                  data_q[idx] <= bus.cpu_wd;
    end
  end

`ifdef DCACHE_STATS_EN
  // The cycle right after a fill completes a load that already counted as a miss.
  logic just_filled;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count   <= '0;
      miss_count  <= '0;
      just_filled <= 1'b0;
    end else begin
      just_filled <= fill_en;
      if (state == IDLE && is_load && cacheable && hit && !just_filled)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_nxt == FETCH)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
